// File: rtl/vc_fifo_pkg.sv
// Shared widths and pointer helpers for the multi-channel FIFO.
// Every vc_fifo file derives its field sizes from these functions.
package vc_fifo_pkg;

  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit compare keeps non-power-of-2 depths wrapping correctly.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// Request/status bundle of the multi-channel FIFO.
// The master side issues requests and the slave side is the FIFO itself.
interface vc_fifo_if
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8
);
  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0]   in;
  logic [CH_W-1:0]         in_ch;
  logic                    add;
  logic [CH_W-1:0]         rd_ch;
  logic                    remove;
  logic [NUM_CH-1:0]       flush;
  logic [DATA_WIDTH-1:0]   front;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH*CNT_W-1:0] count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output in, in_ch, add, rd_ch, remove, flush,
    input  front, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  in, in_ch, add, rd_ch, remove, flush,
    output front, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/vc_fifo_ch_ctrl.sv
// Head/tail/occupancy bookkeeping for one channel of the shared FIFO.
// do_add/do_rem arrive already qualified by the top-level accept logic.
module vc_fifo_ch_ctrl
  import vc_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int PTR_W    = ptr_w(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             do_add,
  input  logic             do_rem,
  input  logic             flush,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] head_next, tail_next;

  assign head_next = PTR_W'(wrap_inc(int'(head_reg), DEPTH));
  assign tail_next = PTR_W'(wrap_inc(int'(tail_reg), DEPTH));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_add) tail_reg <= tail_next;
      if (do_rem) head_reg <= head_next;
      case ({do_add, do_rem})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head        = head_reg;
  assign tail        = tail_reg;
  assign count       = count_reg;
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= CNT_W'(AF_THRESH));
endmodule

// File: rtl/vc_fifo.sv
// Multi-channel FIFO: NUM_CH circular queues sharing one storage array,
// with show-ahead front of the selected read channel and sticky error flags.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = 6
) (
  input  logic     clk,
  input  logic     reset,
  vc_fifo_if.slave bus
);
  localparam int CH_W    = ch_w(NUM_CH);
  localparam int PTR_W   = ptr_w(DEPTH);
  localparam int CNT_W   = cnt_w(DEPTH);
  localparam int ENTRIES = NUM_CH * DEPTH;
  localparam int ADDR_W  = ptr_w(ENTRIES);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  logic [PTR_W-1:0]  head_w  [NUM_CH];
  logic [PTR_W-1:0]  tail_w  [NUM_CH];
  logic [CNT_W-1:0]  count_w [NUM_CH];
  logic [NUM_CH-1:0] in_sel, rd_sel, do_add, do_rem;
  logic [NUM_CH-1:0] full_w, empty_w, af_w, ovf_ch, unf_ch;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              overflow_reg, underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // One-hot decode; an out-of-range channel leaves the vector all zero.
      assign in_sel[gi] = (bus.in_ch == CH_W'(gi));
      assign rd_sel[gi] = (bus.rd_ch == CH_W'(gi));

      assign do_rem[gi] = bus.remove && rd_sel[gi] && !bus.flush[gi] && !empty_w[gi];
      assign do_add[gi] = bus.add && in_sel[gi] && !bus.flush[gi] && (!full_w[gi] || do_rem[gi]);
      assign ovf_ch[gi] = bus.add && in_sel[gi] && !bus.flush[gi] && full_w[gi] && !do_rem[gi];
      assign unf_ch[gi] = bus.remove && rd_sel[gi] && !bus.flush[gi] && empty_w[gi];

      vc_fifo_ch_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
      ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .do_add      (do_add[gi]),
        .do_rem      (do_rem[gi]),
        .flush       (bus.flush[gi]),
        .head        (head_w[gi]),
        .tail        (tail_w[gi]),
        .count       (count_w[gi]),
        .full        (full_w[gi]),
        .empty       (empty_w[gi]),
        .almost_full (af_w[gi])
      );

      assign bus.count[gi*CNT_W +: CNT_W] = count_w[gi];
    end
  endgenerate

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_sel[c]) wr_addr = ADDR_W'(c * DEPTH) + ADDR_W'(tail_w[c]);
      if (rd_sel[c]) rd_addr = ADDR_W'(c * DEPTH) + ADDR_W'(head_w[c]);
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && |do_add) mem[wr_addr] <= bus.in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (|ovf_ch || (bus.add && !(|in_sel)))    overflow_reg  <= 1'b1;
      if (|unf_ch || (bus.remove && !(|rd_sel))) underflow_reg <= 1'b1;
    end
  end

  assign bus.front       = mem[rd_addr];
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almost_full = af_w;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;
endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo (8-bit data, 4 entries, 2 channels, AF at 3).
// Accepted removes are checked by a front-word scoreboard; status by direct compares.
module tb_vc_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [0:0] ch; logic [7:0] data; } exp_t;
  exp_t sb_q[$];

  vc_fifo_if #(.DATA_WIDTH(8), .NUM_CH(2), .DEPTH(4)) bus ();

  vc_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .NUM_CH     (2),
    .AF_THRESH  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [0:0] ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic a, input logic [0:0] ic, input logic [7:0] d,
                      input logic r, input logic [0:0] rc, input logic [1:0] fl);
    bus.add    = a;
    bus.in_ch  = ic;
    bus.in     = d;
    bus.remove = r;
    bus.rd_ch  = rc;
    bus.flush  = fl;
    @(posedge clk);
    #1;
    bus.add    = 1'b0;
    bus.remove = 1'b0;
    bus.flush  = 2'b00;
  endtask

  // Monitor: an accepted remove presents the head word; compare it to the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.remove && !bus.empty[bus.rd_ch] && !bus.flush[bus.rd_ch]) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL pop_front unexpected pop ch=%0d actual=0x%0h expected=none",
                 bus.rd_ch, bus.front);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.front !== e.data || bus.rd_ch !== e.ch) begin
          failures++;
          $display("FAIL pop_front ch=%0d actual=0x%0h expected ch=%0d 0x%0h",
                   bus.rd_ch, bus.front, e.ch, e.data);
        end else begin
          $display("ok   pop_front ch=%0d = 0x%0h", bus.rd_ch, bus.front);
        end
      end
    end
  end

  initial begin
    bus.add = 1'b0; bus.in_ch = '0; bus.in = '0;
    bus.remove = 1'b0; bus.rd_ch = '0; bus.flush = '0;

    // 1: reset, then three adds on ch0
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h3);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_af", 32'(bus.almost_full), 32'h0);
    chk("rst_ovf_unf", {30'h0, bus.overflow, bus.underflow}, 32'h0);
    step(1, 0, 8'h11, 0, 0, 2'b00);
    step(1, 0, 8'h22, 0, 0, 2'b00);
    step(1, 0, 8'h33, 0, 0, 2'b00);
    chk("c1_count0", 32'(bus.count[2:0]), 32'd3);
    chk("c1_af", 32'(bus.almost_full), 32'h1);
    chk("c1_empty", 32'(bus.empty), 32'h2);
    bus.rd_ch = 1'b0; #1;
    chk("c1_front0", 32'(bus.front), 32'h11);

    // 2: fill ch1 and overflow it
    for (int i = 0; i < 4; i++) step(1, 1, 8'hA0 + 8'(i), 0, 1, 2'b00);
    chk("c2_ovf_before", 32'(bus.overflow), 32'h0);
    step(1, 1, 8'hA4, 0, 1, 2'b00);
    chk("c2_full", 32'(bus.full), 32'h2);
    chk("c2_ovf", 32'(bus.overflow), 32'h1);
    chk("c2_count1", 32'(bus.count[5:3]), 32'd4);
    chk("c2_front1", 32'(bus.front), 32'hA0);

    // 3: add+remove on full ch1, then drain through the tail wrap
    push_exp(1, 8'hA0);
    step(1, 1, 8'hB0, 1, 1, 2'b00);
    chk("c3_count1", 32'(bus.count[5:3]), 32'd4);
    chk("c3_front1", 32'(bus.front), 32'hA1);
    push_exp(1, 8'hA1); push_exp(1, 8'hA2); push_exp(1, 8'hA3); push_exp(1, 8'hB0);
    repeat (4) step(0, 0, 8'h00, 1, 1, 2'b00);
    chk("c3_drained", 32'(bus.empty), 32'h2);
    chk("c3_unf", 32'(bus.underflow), 32'h0);

    // 4: drain ch0, then add+remove on empty ch0
    push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(0, 8'h33);
    repeat (3) step(0, 0, 8'h00, 1, 0, 2'b00);
    chk("c4_empty", 32'(bus.empty), 32'h3);
    step(1, 0, 8'h55, 1, 0, 2'b00);
    chk("c4_unf", 32'(bus.underflow), 32'h1);
    chk("c4_count0", 32'(bus.count[2:0]), 32'd1);
    chk("c4_front0", 32'(bus.front), 32'h55);

    // 5: flush ch0 with a concurrent add and remove on ch0
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    chk("c5_rst_flags", {30'h0, bus.overflow, bus.underflow}, 32'h0);
    step(1, 0, 8'h55, 0, 0, 2'b00);
    step(1, 0, 8'h66, 0, 0, 2'b00);
    step(1, 1, 8'hC1, 0, 0, 2'b00);
    step(1, 0, 8'h77, 1, 0, 2'b01);
    chk("c5_count0", 32'(bus.count[2:0]), 32'd0);
    chk("c5_count1", 32'(bus.count[5:3]), 32'd1);
    chk("c5_empty", 32'(bus.empty), 32'h1);
    chk("c5_flags", {30'h0, bus.overflow, bus.underflow}, 32'h0);
    bus.rd_ch = 1'b1; #1;
    chk("c5_front1", 32'(bus.front), 32'hC1);
    step(1, 0, 8'h88, 0, 1, 2'b00);
    bus.rd_ch = 1'b0; #1;
    chk("c5_front0_after", 32'(bus.front), 32'h88);

    // 6: independent channels in one cycle, set both flags, then reset mid-operation
    push_exp(0, 8'h88);
    step(1, 1, 8'hC2, 1, 0, 2'b00);
    chk("c6_counts", 32'(bus.count), {26'h0, 3'd2, 3'd0});
    step(0, 0, 8'h00, 1, 0, 2'b00);
    step(1, 1, 8'hC3, 0, 0, 2'b00);
    step(1, 1, 8'hC4, 0, 0, 2'b00);
    step(1, 1, 8'hC5, 0, 0, 2'b00);
    chk("c6_flags_set", {30'h0, bus.overflow, bus.underflow}, 32'h3);
    bus.add = 1'b1; bus.in_ch = 1'b0; bus.in = 8'h99;
    bus.remove = 1'b1; bus.rd_ch = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.add = 1'b0; bus.remove = 1'b0;
    chk("c6_count", 32'(bus.count), 32'h0);
    chk("c6_empty", 32'(bus.empty), 32'h3);
    chk("c6_flags", {30'h0, bus.overflow, bus.underflow}, 32'h0);

    @(posedge clk); #1;
    chk("sb_leftover", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
